// File: rtl/os_drain_collector.sv
// Bottom-row drain collector for an output-stationary array: sequences output_en,
// captures one row of column psums per cycle into a first-word-fall-through FIFO.
module os_drain_collector #(
    parameter int col     = 8,
    parameter int row     = 8,
    parameter int psum_bw = 16,
    parameter int lat     = 1,
    parameter int depth   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     drain_start,
    input  logic [col*psum_bw-1:0]   in_s,
    output logic                     output_en,
    input  logic                     rd,
    output logic [col*psum_bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_full,
    output logic                     busy,
    output logic                     done
);

    // state | meaning
    // IDLE  | waiting for drain_start
    // WAIT  | request accepted, waiting for row free FIFO entries
    // DRAIN | output_en high for row+lat cycles, capturing row words
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, DONE} state_t;

    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(row + lat + 1);
    localparam int dw = col * psum_bw;

    localparam logic [cw-1:0] cap_first = cw'(lat);
    localparam logic [cw-1:0] cap_last  = cw'(lat + row - 1);
    localparam logic [cw-1:0] drain_end = cw'(row + lat - 1);
    localparam logic [aw:0]   depth_c   = (aw+1)'(depth);
    localparam logic [aw:0]   row_c     = (aw+1)'(row);

    state_t         state, state_nx;
    logic [cw-1:0]  cyc;
    logic [aw-1:0]  wr_ptr, rd_ptr;
    logic [aw:0]    occ;
    logic [dw-1:0]  mem [depth];
    logic           free_ok, push, pop;

    assign free_ok = (depth_c - occ) >= row_c;
    assign push    = (state == DRAIN) && (cyc >= cap_first) && (cyc <= cap_last);
    assign pop     = rd && o_valid;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (drain_start) state_nx = free_ok ? DRAIN : WAIT;
            WAIT:    if (free_ok) state_nx = DRAIN;
            DRAIN:   if (cyc == drain_end) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cyc       <= '0;
            output_en <= 1'b0;
        end else begin
            state     <= state_nx;
            cyc       <= (state == DRAIN) ? cyc + cw'(1) : '0;
            output_en <= (state_nx == DRAIN);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + aw'(1);
            if (pop)  rd_ptr <= rd_ptr + aw'(1);
            if (push && !pop)      occ <= occ + (aw+1)'(1);
            else if (pop && !push) occ <= occ - (aw+1)'(1);
        end
    end

    // Storage is not reset; contents are only visible through o_valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_s;
    end

    assign out     = mem[rd_ptr];
    assign o_valid = (occ != '0);
    assign o_full  = (occ == depth_c);
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    // Space is reserved before DRAIN, so a push into a full FIFO without a pop is a bug.
    no_overflow: assert property (@(posedge clk) disable iff (!reset) !(push && o_full && !pop));

endmodule
